writeback_scoreboard: RTL and testbench
=======================================

WRITEBACK_SCOREBOARD -- requirements
Module: writeback_scoreboard

Interface
REQ-001 The block SHALL have parameter MAX_WAIT, default 2, the number of consecutive cycles md may be denied before it is forced to win.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports issue_valid, issue_long, issue_use1 and issue_use2, each input, 1 bit: issue valid; issue targets the MUL/DIV unit; rs1 used; rs2 used.
REQ-005 The block SHALL have ports issue_rs1, issue_rs2 and issue_rd, each input, 5 bits: the issuing instruction's register indices.
REQ-006 The block SHALL have port stall, output, 1 bit: the issue is refused this cycle.
REQ-007 The block SHALL have ports alu_valid (input, 1), alu_rd (input, 5), alu_data (input, 32) and alu_ready (output, 1): the ALU writeback handshake.
REQ-008 The block SHALL have ports md_valid (input, 1), md_rd (input, 5), md_data (input, 32) and md_ready (output, 1): the MUL/DIV writeback handshake.
REQ-009 The block SHALL have ports rf_we (output, 1), rf_rd (output, 5) and rf_wdata (output, 32): the register-file write port, registered.
REQ-010 The block SHALL have port busy, output, 32 bits: the scoreboard vector, for debug.

Function
REQ-011 A handshake SHALL be accepted in a cycle where valid and ready are both high at the rising edge; md_valid, md_rd and md_data SHALL be held stable until accepted.
REQ-012 stall SHALL be combinational and high when issue_valid is high and any of these holds: issue_use1 with busy[issue_rs1]; issue_use2 with busy[issue_rs2]; busy[issue_rd] (WAW); issue_long with md_pending high.
REQ-013 An issue SHALL be accepted when issue_valid is high and stall is low.
REQ-014 An accepted issue with issue_long high SHALL set md_pending and, if issue_rd != 0, SHALL set busy[issue_rd].
REQ-015 busy[0] SHALL always be 0.
REQ-016 An accepted md handshake SHALL clear busy[md_rd] and md_pending at that edge.
REQ-017 The arbiter FSM SHALL have states ALU_PRIO and MD_FORCE and a wait counter of width ceil(log2(MAX_WAIT+1)).
REQ-018 In ALU_PRIO, alu_ready SHALL be 1 and md_ready SHALL be !alu_valid.
REQ-019 In ALU_PRIO, each cycle with md_valid high and not accepted SHALL increment the counter; reaching MAX_WAIT SHALL move the FSM to MD_FORCE; an md accept SHALL clear the counter.
REQ-020 In MD_FORCE, md_ready SHALL be 1 and alu_ready SHALL be 0.
REQ-021 The FSM SHALL return from MD_FORCE to ALU_PRIO on md accept, with the counter cleared.
REQ-022 The accepted source's rd and data SHALL appear on rf_rd and rf_wdata in the next cycle (1-cycle latency).
REQ-023 rf_we SHALL be 1 in that next cycle only if the accepted rd != 0; otherwise rf_we SHALL be 0 and the handshake still completes.
REQ-024 At most one write SHALL occur per cycle; rf_we SHALL be 0 in any cycle following one with no accept.
REQ-025 A register cleared at edge k SHALL be readable by an issue in cycle k+1, because the file writes on the falling edge mid-cycle; no bypass path SHALL exist.
REQ-026 When an md accept clears register X in the same cycle that an issue reads X, the issue SHALL still stall, because stall is evaluated from pre-edge busy.
REQ-027 An md accept with busy[md_rd] already 0 SHALL be legal and SHALL write normally.

Reset
REQ-028 While RST is high at a rising edge, busy SHALL become 0, md_pending 0, the FSM ALU_PRIO, the counter 0, rf_we 0, rf_rd 0 and rf_wdata 0.
REQ-029 Reset SHALL take priority over simultaneous accepts; a reset arriving mid-operation SHALL discard the pending MUL/DIV write tracking.

Structure
REQ-030 The shared package SHALL hold the FSM state encoding, the register-index width (5), the data width (32) and the MAX_WAIT default.
REQ-031 The block SHALL contain one sub-module, wb_arbiter: the FSM plus the write-port mux and registers; the scoreboard SHALL stay in the top.

Verification
REQ-032 Bench SHALL drive: issue long rd=5; next cycle issue rs1=5 -> stall=1 until md accept of rd=5 with data 0x0000002A; rf_we=1, rf_rd=5 and rf_wdata=0x2A one cycle later; the issue is accepted the cycle after that.
REQ-033 Bench SHALL drive: alu_valid and md_valid continuously, MAX_WAIT=2 -> ALU writes for 2 cycles, then md_ready=1 and alu_ready=0 for one cycle, then ALU priority resumes.
REQ-034 Bench SHALL drive: md accept rd=0, data 0xFFFFFFFF -> rf_we=0 next cycle; busy remains 0.
REQ-035 Bench SHALL drive: second long issue while md_pending=1 -> stall=1; same-cycle md accept -> still stalled; the issue is accepted the following cycle.
REQ-036 Bench SHALL drive: long issue rd=7, then RST for 1 cycle -> busy=0, rf_we=0, FSM ALU_PRIO; an issue reading x7 is accepted immediately.
REQ-037 Bench SHALL drive: WAW case, long rd=3 pending, ALU-class issue rd=3 -> stall=1 until md accept.

Source files
------------

// File: rtl/writeback_scoreboard_pkg.sv
// Shared types and widths for the writeback scoreboard: arbiter state encoding,
// register-index/data widths and the default forced-win threshold.
package writeback_scoreboard_pkg;

    localparam int REG_IDX_W        = 5;
    localparam int DATA_W           = 32;
    localparam int NUM_REGS         = 1 << REG_IDX_W;
    localparam int MAX_WAIT_DEFAULT = 2;

    typedef enum logic [0:0] {
        ALU_PRIO = 1'b0,
        MD_FORCE = 1'b1
    } arb_state_e;

    // Counter width able to hold MAX_WAIT; never narrower than one bit.
    function automatic int wait_cnt_width(input int max_wait);
        int w;
        w = $clog2(max_wait + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : writeback_scoreboard_pkg

// File: rtl/writeback_scoreboard_if.sv
// Writeback bus: ALU and MUL/DIV valid/ready handshakes plus the registered
// register-file write port. The slave side is the scoreboard/arbiter.
interface writeback_scoreboard_if;
    import writeback_scoreboard_pkg::*;

    logic                 alu_valid;
    logic [REG_IDX_W-1:0] alu_rd;
    logic [DATA_W-1:0]    alu_data;
    logic                 alu_ready;

    logic                 md_valid;
    logic [REG_IDX_W-1:0] md_rd;
    logic [DATA_W-1:0]    md_data;
    logic                 md_ready;

    logic                 rf_we;
    logic [REG_IDX_W-1:0] rf_rd;
    logic [DATA_W-1:0]    rf_wdata;

    modport master (
        output alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
        input  alu_ready, md_ready, rf_we, rf_rd, rf_wdata
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
        output alu_ready, md_ready, rf_we, rf_rd, rf_wdata
    );

endinterface : writeback_scoreboard_if

// File: rtl/writeback_scoreboard_wb_arbiter.sv
// Writeback arbiter: ALU has priority, but a MUL/DIV result denied MAX_WAIT
// consecutive cycles is forced through. Also owns the registered RF write port.
module wb_arbiter
    import writeback_scoreboard_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic               clk,
    input  logic               srst,
    writeback_scoreboard_if.slave wb,
    output logic               md_accept_o
);

    localparam int CNT_W = wait_cnt_width(MAX_WAIT);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    arb_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 alu_ready_c, md_ready_c;
    logic                 alu_acc_c, md_acc_c;

    logic                 rf_we_q, rf_we_d;
    logic [REG_IDX_W-1:0] rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0]    rf_wdata_q, rf_wdata_d;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= ALU_PRIO;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_ready_c = 1'b1;
        md_ready_c  = !wb.alu_valid;
        alu_acc_c   = 1'b0;
        md_acc_c    = 1'b0;

        unique case (state_q)
            ALU_PRIO: begin
                alu_ready_c = 1'b1;
                md_ready_c  = !wb.alu_valid;
                alu_acc_c   = wb.alu_valid;
                md_acc_c    = wb.md_valid && md_ready_c;
                if (md_acc_c) begin
                    cnt_d = '0;
                end else if (wb.md_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d >= MAX_CNT) begin
                        state_d = MD_FORCE;
                    end
                end
            end
            MD_FORCE: begin
                alu_ready_c = 1'b0;
                md_ready_c  = 1'b1;
                md_acc_c    = wb.md_valid;
                if (md_acc_c) begin
                    state_d = ALU_PRIO;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ALU_PRIO;
                cnt_d   = '0;
            end
        endcase
    end

    // The two accepts are mutually exclusive by construction of the ready terms.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (md_acc_c) begin
            rf_we_d    = (wb.md_rd != '0);
            rf_rd_d    = wb.md_rd;
            rf_wdata_d = wb.md_data;
        end else if (alu_acc_c) begin
            rf_we_d    = (wb.alu_rd != '0);
            rf_rd_d    = wb.alu_rd;
            rf_wdata_d = wb.alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign wb.alu_ready = alu_ready_c;
    assign wb.md_ready  = md_ready_c;
    assign wb.rf_we     = rf_we_q;
    assign wb.rf_rd     = rf_rd_q;
    assign wb.rf_wdata  = rf_wdata_q;
    assign md_accept_o  = md_acc_c;

endmodule : wb_arbiter

// File: rtl/writeback_scoreboard.sv
// Register scoreboard for an in-order issue stage with one outstanding MUL/DIV
// operation; writeback arbitration and the RF write port live in wb_arbiter.
module writeback_scoreboard
    import writeback_scoreboard_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 issue_valid,
    input  logic                 issue_long,
    input  logic                 issue_use1,
    input  logic                 issue_use2,
    input  logic [REG_IDX_W-1:0] issue_rs1,
    input  logic [REG_IDX_W-1:0] issue_rs2,
    input  logic [REG_IDX_W-1:0] issue_rd,
    output logic                 stall,
    output logic [NUM_REGS-1:0]  busy,
    writeback_scoreboard_if.slave wb
);

    // x0 is never tracked, so only bits 1..NUM_REGS-1 are stored.
    logic [NUM_REGS-1:1] busy_q, busy_d;
    logic [NUM_REGS-1:0] busy_vec;
    logic                md_pending_q, md_pending_d;
    logic                md_accept;
    logic                issue_accept;
    logic                issue_long_accept;

    assign busy_vec = {busy_q, 1'b0};

    // Stall is evaluated from pre-edge busy: a same-cycle clear does not bypass.
    always_comb begin
        stall = 1'b0;
        if (issue_valid) begin
            stall = (issue_use1 && busy_vec[issue_rs1])
                 || (issue_use2 && busy_vec[issue_rs2])
                 || busy_vec[issue_rd]
                 || (issue_long && md_pending_q);
        end
    end

    assign issue_accept      = issue_valid && !stall;
    assign issue_long_accept = issue_accept && issue_long;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_busy
            assign busy_d[gi] = (issue_long_accept && (issue_rd == REG_IDX_W'(gi)))
                             || (busy_q[gi] && !(md_accept && (wb.md_rd == REG_IDX_W'(gi))));
        end
    endgenerate

    assign md_pending_d = issue_long_accept || (md_pending_q && !md_accept);

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q       <= '0;
            md_pending_q <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            md_pending_q <= md_pending_d;
        end
    end

    assign busy = busy_vec;

    wb_arbiter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wb_arbiter (
        .clk         (CLK),
        .srst        (RST),
        .wb          (wb),
        .md_accept_o (md_accept)
    );

endmodule : writeback_scoreboard

// File: tb/tb_writeback_scoreboard.sv
// Directed self-checking bench for writeback_scoreboard: RAW/WAW stalls,
// arbitration fairness, x0 writes, pending-MD stalls and mid-operation reset.
module tb_writeback_scoreboard;

    logic        clk;
    logic        rst;
    logic        issue_valid, issue_long, issue_use1, issue_use2;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        stall;
    logic [31:0] busy;
    int          total;
    int          bad;

    writeback_scoreboard_if wbif ();

    writeback_scoreboard #(.MAX_WAIT(2)) dut (
        .CLK         (clk),
        .RST         (rst),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .issue_use1  (issue_use1),
        .issue_use2  (issue_use2),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .stall       (stall),
        .busy        (busy),
        .wb          (wbif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic v, input logic lng, input logic u1, input logic [4:0] rs1,
                               input logic [4:0] rd);
        issue_valid = v; issue_long = lng; issue_use1 = u1; issue_use2 = 1'b0;
        issue_rs1 = rs1; issue_rs2 = 5'd0; issue_rd = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        wbif.alu_valid = 1'b0; wbif.alu_rd = 5'd0; wbif.alu_data = 32'd0;
        wbif.md_valid = 1'b0; wbif.md_rd = 5'd0; wbif.md_data = 32'd0;
        tick(); tick();
        rst = 1'b0;
        #1;
        total++; if (busy !== 32'd0) begin bad++; $display("FAIL reset_busy: got %h expected 00000000", busy); end
        total++; if (wbif.rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we: got %b expected 0", wbif.rf_we); end
        total++; if (wbif.rf_rd !== 5'd0) begin bad++; $display("FAIL reset_rf_rd: got %0d expected 0", wbif.rf_rd); end
        total++; if (wbif.rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_rf_wdata: got %h expected 0", wbif.rf_wdata); end
        total++; if (wbif.alu_ready !== 1'b1 || wbif.md_ready !== 1'b1) begin bad++;
            $display("FAIL reset_ready: got alu=%b md=%b expected alu=1 md=1", wbif.alu_ready, wbif.md_ready); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", stall); end
    endtask

    task automatic test_raw();
        drive_issue(1'b1, 1'b1, 1'b0, 5'd0, 5'd5);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_long_issue: stall got %b expected 0", stall); end
        tick();
        drive_issue(1'b1, 1'b0, 1'b1, 5'd5, 5'd6);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall_1: got %b expected 1", stall); end
        total++; if (busy !== 32'h0000_0020) begin bad++; $display("FAIL raw_busy: got %h expected 00000020", busy); end
        tick();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall_2: got %b expected 1", stall); end
        wbif.md_valid = 1'b1; wbif.md_rd = 5'd5; wbif.md_data = 32'h0000_002A;
        #1;
        total++; if (wbif.md_ready !== 1'b1) begin bad++; $display("FAIL raw_md_ready: got %b expected 1", wbif.md_ready); end
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall_same_edge: got %b expected 1", stall); end
        tick();
        wbif.md_valid = 1'b0;
        #1;
        total++; if (wbif.rf_we !== 1'b1 || wbif.rf_rd !== 5'd5 || wbif.rf_wdata !== 32'h2A) begin bad++;
            $display("FAIL raw_rf_write: got we=%b rd=%0d data=%h expected we=1 rd=5 data=0000002a",
                     wbif.rf_we, wbif.rf_rd, wbif.rf_wdata); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_release: stall got %b expected 0", stall); end
        total++; if (busy !== 32'd0) begin bad++; $display("FAIL raw_busy_clear: got %h expected 0", busy); end
        tick();
        drive_issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        #1;
        total++; if (wbif.rf_we !== 1'b0) begin bad++; $display("FAIL raw_we_drop: got %b expected 0", wbif.rf_we); end
        total++; if (busy !== 32'd0) begin bad++; $display("FAIL raw_alu_issue_untracked: busy got %h expected 0", busy); end
    endtask

    task automatic test_arbitration();
        logic [3:0] exp_alu_rdy;
        logic [3:0] exp_md_rdy;
        logic [4:0] exp_rd  [4];
        logic [31:0] exp_dat [4];
        exp_alu_rdy = 4'b1011;  // bit i = cycle i
        exp_md_rdy  = 4'b0100;
        exp_rd[0] = 5'd1; exp_rd[1] = 5'd1; exp_rd[2] = 5'd2; exp_rd[3] = 5'd1;
        exp_dat[0] = 32'h11; exp_dat[1] = 32'h11; exp_dat[2] = 32'h22; exp_dat[3] = 32'h11;
        wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd1; wbif.alu_data = 32'h11;
        wbif.md_valid  = 1'b1; wbif.md_rd  = 5'd2; wbif.md_data  = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (wbif.alu_ready !== exp_alu_rdy[i] || wbif.md_ready !== exp_md_rdy[i]) begin bad++;
                $display("FAIL arb_ready_c%0d: got alu=%b md=%b expected alu=%b md=%b", i,
                         wbif.alu_ready, wbif.md_ready, exp_alu_rdy[i], exp_md_rdy[i]); end
            tick();
            total++; if (wbif.rf_we !== 1'b1 || wbif.rf_rd !== exp_rd[i] || wbif.rf_wdata !== exp_dat[i]) begin bad++;
                $display("FAIL arb_write_c%0d: got we=%b rd=%0d data=%h expected we=1 rd=%0d data=%h", i,
                         wbif.rf_we, wbif.rf_rd, wbif.rf_wdata, exp_rd[i], exp_dat[i]); end
        end
        wbif.alu_valid = 1'b0; wbif.md_valid = 1'b0;
        tick();
    endtask

    task automatic test_rd_zero();
        wbif.md_valid = 1'b1; wbif.md_rd = 5'd0; wbif.md_data = 32'hFFFF_FFFF;
        #1;
        total++; if (wbif.md_ready !== 1'b1) begin bad++; $display("FAIL rd0_md_ready: got %b expected 1", wbif.md_ready); end
        tick();
        wbif.md_valid = 1'b0;
        #1;
        total++; if (wbif.rf_we !== 1'b0) begin bad++; $display("FAIL rd0_rf_we: got %b expected 0", wbif.rf_we); end
        total++; if (wbif.rf_wdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rd0_rf_wdata: got %h expected ffffffff", wbif.rf_wdata); end
        total++; if (busy !== 32'd0) begin bad++; $display("FAIL rd0_busy: got %h expected 0", busy); end
    endtask

    task automatic test_md_pending();
        drive_issue(1'b1, 1'b1, 1'b0, 5'd0, 5'd8);
        tick();
        drive_issue(1'b1, 1'b1, 1'b0, 5'd0, 5'd9);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL pend_stall_1: got %b expected 1", stall); end
        tick();
        wbif.md_valid = 1'b1; wbif.md_rd = 5'd8; wbif.md_data = 32'h88;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL pend_stall_same_cycle: got %b expected 1", stall); end
        tick();
        wbif.md_valid = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL pend_release: stall got %b expected 0", stall); end
        tick();
        drive_issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        #1;
        total++; if (busy !== 32'h0000_0200) begin bad++; $display("FAIL pend_second_issue: busy got %h expected 00000200", busy); end
        wbif.md_valid = 1'b1; wbif.md_rd = 5'd9; wbif.md_data = 32'h99;
        tick();
        wbif.md_valid = 1'b0;
        #1;
        total++; if (busy !== 32'd0 || wbif.rf_rd !== 5'd9 || wbif.rf_wdata !== 32'h99) begin bad++;
            $display("FAIL pend_drain: got busy=%h rd=%0d data=%h expected busy=0 rd=9 data=00000099",
                     busy, wbif.rf_rd, wbif.rf_wdata); end
    endtask

    task automatic test_waw();
        drive_issue(1'b1, 1'b1, 1'b0, 5'd0, 5'd3);
        tick();
        drive_issue(1'b1, 1'b0, 1'b0, 5'd0, 5'd3);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL waw_stall_1: got %b expected 1", stall); end
        tick();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL waw_stall_2: got %b expected 1", stall); end
        wbif.md_valid = 1'b1; wbif.md_rd = 5'd3; wbif.md_data = 32'h33;
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL waw_stall_same_cycle: got %b expected 1", stall); end
        tick();
        wbif.md_valid = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL waw_release: stall got %b expected 0", stall); end
        tick();
        drive_issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        #1;
        total++; if (busy !== 32'd0) begin bad++; $display("FAIL waw_busy: got %h expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        drive_issue(1'b1, 1'b1, 1'b0, 5'd0, 5'd7);
        tick();
        drive_issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        #1;
        total++; if (busy !== 32'h0000_0080) begin bad++; $display("FAIL rstmid_busy_set: got %h expected 00000080", busy); end
        // Two denied MD cycles push the arbiter into MD_FORCE before reset.
        wbif.alu_valid = 1'b1; wbif.alu_rd = 5'd4; wbif.alu_data = 32'h44;
        wbif.md_valid  = 1'b1; wbif.md_rd  = 5'd7; wbif.md_data  = 32'h77;
        tick(); tick();
        total++; if (wbif.alu_ready !== 1'b0) begin bad++; $display("FAIL rstmid_forced: alu_ready got %b expected 0", wbif.alu_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wbif.md_valid = 1'b0;
        #1;
        total++; if (busy !== 32'd0 || wbif.rf_we !== 1'b0) begin bad++;
            $display("FAIL rstmid_state: got busy=%h we=%b expected busy=0 we=0", busy, wbif.rf_we); end
        total++; if (wbif.alu_ready !== 1'b1 || wbif.md_ready !== 1'b0) begin bad++;
            $display("FAIL rstmid_fsm: got alu=%b md=%b expected alu=1 md=0", wbif.alu_ready, wbif.md_ready); end
        wbif.alu_valid = 1'b0;
        drive_issue(1'b1, 1'b1, 1'b1, 5'd7, 5'd10);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstmid_issue: stall got %b expected 0", stall); end
        tick();
        drive_issue(1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
        #1;
        total++; if (busy !== 32'h0000_0400) begin bad++; $display("FAIL rstmid_new_issue: busy got %h expected 00000400", busy); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_raw();
        test_arbitration();
        test_rd_zero();
        test_md_pending();
        test_waw();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_writeback_scoreboard
